// File: rtl/tdc_decoder.sv
// TDC thermometer decoder: bubble filter, edge search, DCO phase and period estimate.
// Three register stages: capture, filter, edge/arithmetic with registered results.
module tdc_decoder #(
  parameter int N           = 64,
  parameter int PW          = 7,
  parameter int INIT_PERIOD = 36,
  parameter int FB          = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     samples,
  input  logic [2:0]       avg_log2,
  output logic [PW-1:0]    phase_out,
  output logic [PW+FB-1:0] period_avg,
  output logic             valid,
  output logic             edge_err,
  output logic [7:0]       err_cnt
);
  localparam int AW  = $clog2(N);
  localparam int PAW = PW + FB;
  localparam logic [PAW-1:0] PERIOD_RST = PAW'(INIT_PERIOD) << FB;
  localparam logic [AW:0]    MEAS_MAX   = (AW+1)'(2**PW - 2);

  logic [N-1:0]   samp_q, samp_d, filt_q, filt_d;
  logic           en1_q, en1_d, en2_q, en2_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [PAW-1:0] period_q, period_d;
  logic           valid_q, valid_d, err_q, err_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [N+1:0]          ext;
  logic                  rise_found, fall_found;
  logic [AW-1:0]         rise_pos, fall_pos, half;
  logic [AW:0]           meas;
  logic signed [PAW:0]   delta, delta_sh;
  logic [PAW:0]          rnd_sum;
  logic [PW:0]           fb_phase;

  always_comb begin
    samp_d = samples;
    en1_d  = en;
    // Edge taps replicated so the end bits vote with themselves.
    ext    = {samp_q[N-1], samp_q, samp_q[0]};
    for (int k = 0; k < N; k++)
      filt_d[k] = (ext[k] & ext[k+1]) | (ext[k] & ext[k+2]) | (ext[k+1] & ext[k+2]);
    en2_d  = en1_q;

    // Scan downward so the lowest matching tap is the one that sticks.
    rise_found = 1'b0;
    rise_pos   = '0;
    fall_found = 1'b0;
    fall_pos   = '0;
    for (int k = N-1; k >= 1; k--) begin
      if (!filt_q[k-1] && filt_q[k]) begin
        rise_found = 1'b1;
        rise_pos   = AW'(k);
      end
      if (filt_q[k-1] && !filt_q[k]) begin
        fall_found = 1'b1;
        fall_pos   = AW'(k);
      end
    end

    half     = (rise_pos > fall_pos) ? rise_pos - fall_pos : fall_pos - rise_pos;
    meas     = {half, 1'b0};
    delta    = $signed({1'b0, PAW'(meas) << FB}) - $signed({1'b0, period_q});
    delta_sh = delta >>> avg_log2;

    // Fallback uses the pre-update period, rounded to whole taps.
    rnd_sum  = {1'b0, period_q} + (PAW+1)'(1 << FB);
    fb_phase = (PW+1)'(fall_pos) + {1'b0, rnd_sum[PAW:FB+1]};

    phase_d  = phase_q;
    period_d = period_q;
    valid_d  = en2_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    if (en2_q) begin
      if (rise_found && fall_found && meas >= (AW+1)'(2) && meas <= MEAS_MAX)
        period_d = period_q + delta_sh[PAW-1:0];
      if (rise_found)
        phase_d = PW'(rise_pos);
      else if (fall_found)
        phase_d = fb_phase[PW] ? '1 : fb_phase[PW-1:0];
      else begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      en1_q    <= 1'b0;
      filt_q   <= '0;
      en2_q    <= 1'b0;
      phase_q  <= '0;
      period_q <= PERIOD_RST;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      samp_q   <= samp_d;
      en1_q    <= en1_d;
      filt_q   <= filt_d;
      en2_q    <= en2_d;
      phase_q  <= phase_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign phase_out  = phase_q;
  assign period_avg = period_q;
  assign valid      = valid_q;
  assign edge_err   = err_q;
  assign err_cnt    = cnt_q;
endmodule

// File: tb/tb_tdc_decoder.sv
// Directed bench for tdc_decoder with hand-computed expected values.
module tb_tdc_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] samples;
  logic [2:0]  avg_log2;
  logic [6:0]  phase_out;
  logic [12:0] period_avg;
  logic        valid, edge_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W_CLEAN  = 64'hFFFF_FFFF_F000_03FF;
  localparam logic [63:0] W_BUBBLE = 64'hFFFF_FFFF_F000_83FF;
  localparam logic [63:0] W_FALL   = 64'h0000_0000_000F_FFFF;
  localparam logic [63:0] W_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] W_AVG    = 64'hFFFF_FFFF_C000_03FF;

  tdc_decoder dut (
    .clk(clk), .rst(rst), .en(en), .samples(samples), .avg_log2(avg_log2),
    .phase_out(phase_out), .period_avg(period_avg), .valid(valid),
    .edge_err(edge_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One word with en=1, then bubbles; returns at the negedge after the
  // third capturing edge, where the result must be visible.
  task automatic run_word(input logic [63:0] w, input string tag);
    @(negedge clk); samples = w; en = 1'b1;
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk({tag, "_early_valid"}, valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, valid, 1);
  endtask

  initial begin
    bit all_err_ok;
    rst = 1'b1; en = 1'b0; samples = '0; avg_log2 = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase", phase_out, 0);
    chk("rst_period", period_avg, 2304);
    chk("rst_valid", valid, 0);
    chk("rst_edge_err", edge_err, 0);
    chk("rst_err_cnt", err_cnt, 0);

    run_word(W_CLEAN, "clean");
    chk("clean_phase", phase_out, 28);
    chk("clean_period", period_avg, 2304);
    chk("clean_edge_err", edge_err, 0);
    @(negedge clk);
    chk("clean_bubble_valid", valid, 0);

    run_word(W_BUBBLE, "bubble");
    chk("bubble_phase", phase_out, 28);
    chk("bubble_period", period_avg, 2304);

    run_word(W_FALL, "fall");
    chk("fall_phase", phase_out, 38);
    chk("fall_period", period_avg, 2304);
    chk("fall_edge_err", edge_err, 0);

    // No edge held for 300 cycles
    all_err_ok = 1'b1;
    @(negedge clk); samples = W_ONES; en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid && (edge_err !== 1'b1 || phase_out !== 7'd38)) all_err_ok = 1'b0;
      if (!valid && edge_err !== 1'b0) all_err_ok = 1'b0;
    end
    chk("noedge_flags", all_err_ok, 1);
    chk("noedge_err_cnt", err_cnt, 255);
    chk("noedge_phase", phase_out, 38);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("noedge_idle_valid", valid, 0);
    chk("noedge_idle_edge_err", edge_err, 0);
    chk("noedge_cnt_held", err_cnt, 255);

    avg_log2 = 3'd2;
    run_word(W_AVG, "avg1");
    chk("avg1_period", period_avg, 2368);
    chk("avg1_phase", phase_out, 30);
    run_word(W_AVG, "avg2");
    chk("avg2_period", period_avg, 2416);

    // Reset while a stream is in flight
    @(negedge clk); samples = W_AVG; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_period", period_avg, 2304);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_phase", phase_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid1", valid, 0);
    @(negedge clk);
    chk("post_rst_valid2", valid, 0);
    @(negedge clk);
    chk("post_rst_valid3", valid, 1);
    chk("post_rst_period", period_avg, 2368);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
